// File: rtl/hc_write_arbiter.sv
// hc_write_arbiter: shares one CCI-P write-request port among N cores.
// The arbitration is round-robin, and a burst lock keeps a core's stream contiguous.
// req_ready, locked and idle are combinational. The wr_* fields, grant_id and
// beat_count are registered, so they appear one cycle after the accept.
module hc_write_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned CMD_W     = 2,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned OFF_W     = 42,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned CMD_NONE  = 0,
  parameter int unsigned BURST_MAX = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N-1:0]            req_valid,
  input  logic [N-1:0]            req_last,
  input  logic [N*CMD_W-1:0]      req_cmd,
  input  logic [N*ID_W-1:0]       req_id,
  input  logic [N*OFF_W-1:0]      req_offset,
  input  logic [N*DATA_W-1:0]     req_data,
  output logic [N-1:0]            req_ready,
  input  logic                    wr_full,
  output logic [CMD_W-1:0]        wr_cmd,
  output logic [ID_W-1:0]         wr_id,
  output logic [OFF_W-1:0]        wr_offset,
  output logic [DATA_W-1:0]       wr_data,
  output logic [$clog2(N)-1:0]    grant_id,
  output logic                    locked,
  output logic                    idle,
  output logic [31:0]             beat_count
);

  localparam int unsigned GW  = $clog2(N);
  localparam int unsigned BCW = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0]   BURST_LAST = BCW'(BURST_MAX - 1);
  localparam logic [CMD_W-1:0] CMD_IDLE   = CMD_W'(CMD_NONE);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      owner_q, owner_d;
  logic [GW-1:0]      last_winner_q, last_winner_d;
  logic [BCW-1:0]     burst_cnt_q, burst_cnt_d;

  logic [CMD_W-1:0]   wr_cmd_q;
  logic [ID_W-1:0]    wr_id_q;
  logic [OFF_W-1:0]   wr_offset_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [GW-1:0]      grant_id_q;
  logic [31:0]        beat_count_q;

  logic [GW-1:0]      cand;
  logic               cand_valid;
  logic               accept;
  logic               cand_last;
  logic [CMD_W-1:0]   sel_cmd;
  logic [ID_W-1:0]    sel_id;
  logic [OFF_W-1:0]   sel_offset;
  logic [DATA_W-1:0]  sel_data;

  // Candidate pick: the lock owner only, or a round-robin search starting after last_winner
  always_comb begin
    int unsigned idx;
    idx        = 0;
    cand       = '0;
    cand_valid = 1'b0;
    if (state_q == S_LOCKED) begin
      cand       = owner_q;
      cand_valid = req_valid[owner_q];
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = (32'(last_winner_q) + k) % N;
        if (!cand_valid && req_valid[GW'(idx)]) begin
          cand       = GW'(idx);
          cand_valid = 1'b1;
        end
      end
    end
  end

  // Accept gating and the one-hot ready vector
  always_comb begin
    accept    = enable & ~wr_full & ~reset & cand_valid;
    req_ready = accept ? (N'(1) << cand) : '0;
  end

  // Mux the candidate's payload fields
  always_comb begin
    cand_last  = 1'b0;
    sel_cmd    = '0;
    sel_id     = '0;
    sel_offset = '0;
    sel_data   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (GW'(i) == cand) begin
        cand_last  = req_last[i];
        sel_cmd    = req_cmd[i*CMD_W +: CMD_W];
        sel_id     = req_id[i*ID_W +: ID_W];
        sel_offset = req_offset[i*OFF_W +: OFF_W];
        sel_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state: lock entry on a non-last beat, release on last beat or burst cap
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_winner_d = cand;
          if (!cand_last && (BURST_MAX > 1)) begin
            state_d     = S_LOCKED;
            owner_d     = cand;
            burst_cnt_d = BCW'(1);
          end
        end
      end
      S_LOCKED: begin
        if (accept) begin
          if (cand_last || (burst_cnt_q == BURST_LAST)) begin
            state_d       = S_IDLE;
            burst_cnt_d   = '0;
            last_winner_d = owner_q;
          end else begin
            burst_cnt_d = burst_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aims the pointer at N-1 so core 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      last_winner_q <= GW'(N - 1);
      burst_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

  // Issue registers: wr_cmd pulses once per accepted beat, other fields hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cmd_q     <= CMD_IDLE;
      wr_id_q      <= '0;
      wr_offset_q  <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= '0;
      beat_count_q <= '0;
    end else if (accept) begin
      wr_cmd_q     <= sel_cmd;
      wr_id_q      <= sel_id;
      wr_offset_q  <= sel_offset;
      wr_data_q    <= sel_data;
      grant_id_q   <= cand;
      beat_count_q <= beat_count_q + 32'd1;
    end else begin
      wr_cmd_q     <= CMD_IDLE;
    end
  end

  assign wr_cmd     = wr_cmd_q;
  assign wr_id      = wr_id_q;
  assign wr_offset  = wr_offset_q;
  assign wr_data    = wr_data_q;
  assign grant_id   = grant_id_q;
  assign beat_count = beat_count_q;
  assign locked     = (state_q == S_LOCKED);
  assign idle       = (state_q == S_IDLE) & ~|req_valid;

endmodule

// File: tb/tb_hc_write_arbiter.sv
// Scoreboard bench for hc_write_arbiter. N=3 exercises the non-power-of-two
// wrap, and BURST_MAX=4 makes the burst cap trigger often.
module tb_hc_write_arbiter;

  localparam int unsigned N         = 3;
  localparam int unsigned CMD_W     = 2;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned OFF_W     = 42;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned CMD_NONE  = 0;
  localparam int unsigned BURST_MAX = 4;
  localparam int unsigned GW        = $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [N-1:0]         req_valid, req_last, req_ready;
  logic [N*CMD_W-1:0]   req_cmd;
  logic [N*ID_W-1:0]    req_id;
  logic [N*OFF_W-1:0]   req_offset;
  logic [N*DATA_W-1:0]  req_data;
  logic                 wr_full;
  logic [CMD_W-1:0]     wr_cmd;
  logic [ID_W-1:0]      wr_id;
  logic [OFF_W-1:0]     wr_offset;
  logic [DATA_W-1:0]    wr_data;
  logic [GW-1:0]        grant_id;
  logic                 locked, idle;
  logic [31:0]          beat_count;

  hc_write_arbiter #(
    .N(N), .CMD_W(CMD_W), .ID_W(ID_W), .OFF_W(OFF_W), .DATA_W(DATA_W),
    .CMD_NONE(CMD_NONE), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_last(req_last), .req_cmd(req_cmd),
    .req_id(req_id), .req_offset(req_offset), .req_data(req_data),
    .req_ready(req_ready), .wr_full(wr_full), .wr_cmd(wr_cmd),
    .wr_id(wr_id), .wr_offset(wr_offset), .wr_data(wr_data),
    .grant_id(grant_id), .locked(locked), .idle(idle), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                tag;
    logic [CMD_W-1:0]  cmd;
    logic [ID_W-1:0]   id;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
    int                gid;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: lock owner, beats taken in the current burst, pointer, beat total.
  bit          m_locked;
  int          m_owner, m_lw, m_beats;
  logic [31:0] m_count;

  logic [CMD_W-1:0]  cmd_a  [N];
  logic [ID_W-1:0]   id_a   [N];
  logic [OFF_W-1:0]  off_a  [N];
  logic [DATA_W-1:0] data_a [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_lw     = int'(N) - 1;
    m_beats  = 0;
    m_count  = '0;
  endtask

  // Drives one cycle from a negedge, checks the combinational outputs, and advances the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input bit en, input bit full);
    int w;
    int c;
    logic [N-1:0] exp_rdy;
    exp_t e;
    enable    = en;
    wr_full   = full;
    req_valid = v;
    req_last  = l;
    for (int i = 0; i < int'(N); i++) begin
      cmd_a[i]  = CMD_W'($urandom_range(1, 3));
      id_a[i]   = ID_W'($urandom);
      off_a[i]  = OFF_W'({$urandom, $urandom});
      data_a[i] = DATA_W'({$urandom, $urandom});
      req_cmd[i*CMD_W +: CMD_W]    = cmd_a[i];
      req_id[i*ID_W +: ID_W]       = id_a[i];
      req_offset[i*OFF_W +: OFF_W] = off_a[i];
      req_data[i*DATA_W +: DATA_W] = data_a[i];
    end
    #1;
    w = -1;
    if (en && !full) begin
      if (m_locked) begin
        if (v[GW'(m_owner)]) w = m_owner;
      end else begin
        for (int k = 1; k <= int'(N); k++) begin
          c = (m_lw + k) % int'(N);
          if (w < 0 && v[GW'(c)]) w = c;
        end
      end
    end
    exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("idle", 64'(idle), 64'(!m_locked && (v == '0)));
    chk("beat_count", 64'(beat_count), 64'(m_count));
    if (w >= 0) begin
      e.tag  = cyc;
      e.cmd  = cmd_a[w];
      e.id   = id_a[w];
      e.off  = off_a[w];
      e.data = data_a[w];
      e.gid  = w;
      q.push_back(e);
      m_count = m_count + 32'd1;
      if (!m_locked) begin
        m_lw = w;
        if (!l[GW'(w)] && BURST_MAX > 1) begin
          m_locked = 1'b1;
          m_owner  = w;
          m_beats  = 1;
        end
      end else begin
        m_beats++;
        if (l[GW'(w)] || m_beats == int'(BURST_MAX)) begin
          m_locked = 1'b0;
          m_lw     = m_owner;
        end
      end
    end
    @(negedge clk);
  endtask

  // Monitor: every wr_cmd pulse must match the oldest expected beat, one cycle after its accept.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (q.size() > 0 && q[0].tag < cyc - 1) begin
          checks++;
          errors++;
          $display("FAIL wr_pulse: got none expected beat from core %0d accepted at cycle %0d", q[0].gid, q[0].tag);
          void'(q.pop_front());
        end
        if (wr_cmd != CMD_W'(CMD_NONE)) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_pulse: got cmd %0h expected CMD_NONE (cycle %0d)", wr_cmd, cyc);
          end else begin
            e = q.pop_front();
            chk("wr_latency", 64'(cyc - 1), 64'(e.tag));
            chk("wr_cmd", 64'(wr_cmd), 64'(e.cmd));
            chk("wr_id", 64'(wr_id), 64'(e.id));
            chk("wr_offset", 64'(wr_offset), 64'(e.off));
            chk("wr_data", 64'(wr_data), 64'(e.data));
            chk("grant_id", 64'(grant_id), 64'(e.gid));
          end
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    wr_full    = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_cmd    = '0;
    req_id     = '0;
    req_offset = '0;
    req_data   = '0;
    model_reset();
    #12;
    chk("rst_wr_cmd", 64'(wr_cmd), 64'(CMD_NONE));
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Plain round robin with single-beat requests
    repeat (8) step('1, '1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);

    // Core 2 five-beat burst with the other cores also requesting
    for (int b = 1; b <= 5; b++) step(3'b111, (b == 5) ? 3'b111 : 3'b011, 1'b1, 1'b0);
    step(3'b111, 3'b111, 1'b1, 1'b0);

    // Full back-pressure in the middle of a burst
    step(3'b011, 3'b010, 1'b1, 1'b0);
    step(3'b011, 3'b010, 1'b1, 1'b0);
    repeat (3) step(3'b011, 3'b010, 1'b1, 1'b1);
    repeat (3) step(3'b011, 3'b010, 1'b1, 1'b0);

    // Owner bubble while the other cores request, followed by an enable drop during the lock
    step(3'b010, 3'b000, 1'b1, 1'b0);
    repeat (2) step(3'b101, 3'b111, 1'b1, 1'b0);
    repeat (2) step(3'b111, 3'b000, 1'b0, 1'b0);
    step(3'b010, 3'b010, 1'b1, 1'b0);

    // Random traffic
    repeat (3000) begin
      step(N'($urandom), N'($urandom | $urandom),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0));
    end

    // Finish any burst still open, then lock core 1 at burst count 3 and reset
    for (int t = 0; t < 10 && m_locked; t++) step('1, '1, 1'b1, 1'b0);
    repeat (3) step(3'b010, 3'b000, 1'b1, 1'b0);
    chk("pre_reset_locked", 64'(locked), 64'(m_locked));
    req_valid = '1;
    #3;
    reset = 1'b1;
    #1;
    chk("async_wr_cmd", 64'(wr_cmd), 64'(CMD_NONE));
    chk("async_grant_id", 64'(grant_id), 64'd0);
    chk("async_locked", 64'(locked), 64'd0);
    chk("async_beat_count", 64'(beat_count), 64'd0);
    chk("async_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    model_reset();
    step('1, '1, 1'b1, 1'b0);
    repeat (4) step(N'($urandom), '1, 1'b1, 1'b0);

    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    chk("queue_drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc_write_arbiter.md
Name: hc_write_arbiter

Overview:
- Shares the single write-request port of the CCI-P requestor (control cmd/id/offset plus tx cache-line data) among N accelerator cores.
- Round-robin grant with optional burst lock, so one core's stream writes stay contiguous.
- Back-pressure comes from the requestor write-FIFO full status.
- Sits between the cores and the requestor's write-request/tx-data interface.

Parameters:
- N, 4, number of requesting cores (2..16).
- CMD_W, 2, request command width.
- ID_W, 4, buffer id width.
- OFF_W, 42, cache-line offset width.
- DATA_W, 512, cache-line data width.
- CMD_NONE, 0, command value driven when no request is issued.
- BURST_MAX, 64, maximum beats a locked owner may hold the grant (1..1024).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  arbitration allowed (driven from the control-start condition)
- req_valid  in  N  core i presents a write beat
- req_last  in  N  beat ends core i's burst; 0 requests lock
- req_cmd  in  N*CMD_W  per-core command, slice i at [i*CMD_W +: CMD_W]
- req_id  in  N*ID_W  per-core buffer id
- req_offset  in  N*OFF_W  per-core offset
- req_data  in  N*DATA_W  per-core cache-line data
- req_ready  out  N  beat of core i accepted this cycle
- wr_full  in  1  requestor write FIFO near-full (registered status)
- wr_cmd  out  CMD_W  issued command, CMD_NONE when idle
- wr_id  out  ID_W  issued id
- wr_offset  out  OFF_W  issued offset
- wr_data  out  DATA_W  issued data
- grant_id  out  $clog2(N)  index of the last accepted core
- locked  out  1  burst lock held
- idle  out  1  no lock held and no req_valid asserted
- beat_count  out  32  total accepted beats

Behaviour:
- Reset (async) values:
  - state S_IDLE; last_winner = N-1, so core 0 has first priority.
  - req_ready = 0; wr_cmd = CMD_NONE; wr_id/wr_offset/wr_data = 0.
  - grant_id = 0; locked = 0; beat_count = 0; burst_cnt = 0.
- Accept condition: accept = enable & ~wr_full & candidate valid.
  - req_ready is combinational and one-hot or zero.
  - A beat transfers when req_valid[i] & req_ready[i].
- Candidate selection:
  - S_IDLE: first i with req_valid[i] searching from (last_winner+1) mod N upward, wrapping.
  - S_LOCKED: the owner only; other cores never get ready.
- Output latency: 1 cycle. On the edge after an accept, wr_* takes the accepted core's fields and grant_id = i. Otherwise wr_cmd = CMD_NONE; other wr_* fields hold. The requestor enqueues on wr_cmd != CMD_NONE, so wr_cmd is a single-cycle pulse per beat.
- FSM:
  - S_IDLE -> S_LOCKED on accept with req_last = 0 and BURST_MAX > 1. Owner = i, burst_cnt = 1.
  - S_IDLE stays S_IDLE on accept with req_last = 1. last_winner = i on every accept in S_IDLE.
  - S_LOCKED, accept with req_last = 1 or burst_cnt == BURST_MAX-1 -> S_IDLE, burst_cnt = 0, last_winner = owner.
  - S_LOCKED, accept otherwise: burst_cnt++.
  - S_LOCKED, owner req_valid = 0: stay locked with a bubble; no timeout.
- locked = (state == S_LOCKED). idle = (state == S_IDLE) & ~|req_valid. Both combinational from state.
- wr_full = 1 or enable = 0: all ready = 0; state, owner, last_winner and burst_cnt held. Lock survives enable toggling.
- beat_count += 1 per accept, wraps 2^32-1 -> 0.
- Width rules:
  - burst_cnt is $clog2(BURST_MAX+1) bits.
  - The wrap of the priority pointer is explicit modulo N, correct for non-power-of-2 N.
- Async reset mid-burst drops the lock immediately. The partially sent burst is not completed.

Test Plan:
- N=4, all req_valid=1, req_last=1 continuously, wr_full=0, enable=1 -> grant order 0,1,2,3,0,…; wr_cmd pulses every cycle, one cycle after each ready; beat_count=8 after 8 cycles.
- Core 2 sends 5 beats (req_last on 5th) while cores 0,1,3 are valid -> req_ready only to core 2 for those 5 beats, locked=1 from beat 1 through beat 4; next grant to core 3.
- BURST_MAX=4, core 1 holds req_last=0 for 10 beats with core 0 valid -> lock released after beat 4; core 2/3/0 round robin resumes; core 1 re-acquires later.
- wr_full=1 for 3 cycles mid-burst -> req_ready=0 and wr_cmd=CMD_NONE for those cycles; the burst resumes with the same owner and burst_cnt unchanged.
- Owner deasserts req_valid for 2 cycles inside a lock while others are valid -> no other core granted; locked stays 1; idle=0.
- Assert reset during S_LOCKED at burst_cnt=3 -> all outputs return to reset values asynchronously; after release, core 0 wins first.
